// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one partial product per clock, with
// valid/ready handshakes on both sides and a per-operation signed/unsigned mode.
module booth_r4_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int NDIG = WIDTH / 2 + 1;
    localparam int PW   = 2 * WIDTH;
    localparam int EW   = WIDTH + 2;
    localparam int CW   = $clog2(NDIG);
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [EW:0]     mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   product_q, product_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [PW-1:0]   a_wide;
    logic [EW-1:0]   b_ext;
    logic [PW-1:0]   term;

    // The multiplicand is held pre-extended to the full product width and
    // shifted left two places per step, so no variable shifter is needed.
    always_comb begin
        if (signed_mode) begin
            a_wide = {{WIDTH{a[WIDTH-1]}}, a};
            b_ext  = {{2{b[WIDTH-1]}}, b};
        end else begin
            a_wide = {{WIDTH{1'b0}}, a};
            b_ext  = {2'b00, b};
        end
    end

    always_comb begin
        term = '0;
        case (mplier_q[2:0])
            3'b001, 3'b010: term = mcand_q;
            3'b011:         term = mcand_q << 1;
            3'b100:         term = ~(mcand_q << 1) + PW'(1);
            3'b101, 3'b110: term = ~mcand_q + PW'(1);
            default:        term = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mcand_d  = a_wide;
                    mplier_d = {b_ext, 1'b0};
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_q + term;
                mcand_d  = mcand_q << 2;
                mplier_d = mplier_q >> 2;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_DIG) begin
                    product_d = acc_q + term;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered so that in_ready stays low during reset and rises on the first edge after it.
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            product_q  <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            product_q  <= product_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = product_q;

endmodule
